// File: rtl/stg_1_if.sv
// Instruction-fetch stage: PC, credit-limited imem requests, prefetch FIFO and IF->ID register.
// Define IF_PERF_CNT_EN to add the perf_bubbles / perf_stalls counter outputs.
module stg_1_if #(
  parameter int unsigned        INSTR_W    = 32,
  parameter int unsigned        PC_W       = 16,
  parameter int unsigned        PC_STEP    = 4,
  parameter logic [PC_W-1:0]    RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = '0
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  input  logic               s_id_stall,
  input  logic               s_redirect,
  input  logic [PC_W-1:0]    s_redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [INSTR_W-1:0] r_id_instr,
  output logic [PC_W-1:0]    r_id_pc,
  output logic               r_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_bubbles,
  output logic [31:0]        perf_stalls
`endif
);

  localparam int unsigned      PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   outstanding_q, outstanding_d;
  logic [CNT_W-1:0]   discard_q, discard_d;
  logic [PTR_W-1:0]   alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  logic               run_q;
  logic [INSTR_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PC_W-1:0]    fifo_pc_q   [FIFO_DEPTH];
  logic [INSTR_W-1:0] id_instr_q;
  logic [PC_W-1:0]    id_pc_q;
  logic               id_valid_q;

  logic [CNT_W:0]     credit_sum;
  logic               req_fire;
  logic               resp_drop;
  logic               push;
  logic               pop;

  // Stale responses from before a redirect still hold a credit until they return.
  assign credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = run_q && !s_redirect && (credit_sum < {1'b0, DEPTH_C});
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = s_redirect || (discard_q != '0);
  assign push           = imem_resp_valid && !resp_drop;
  assign pop            = !s_id_stall && !s_redirect && (count_q != '0);

  always_comb begin
    // NOTE: every *_d is given its hold value first so no path leaves one unassigned (no latch).
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (req_fire) pc_d = pc_q + PC_W'(PC_STEP);

    case ({req_fire, imem_resp_valid})
      2'b10:   outstanding_d = outstanding_q + ONE_C;
      2'b01:   outstanding_d = outstanding_q - ONE_C;
      default: outstanding_d = outstanding_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    if (imem_resp_valid && (discard_q != '0)) discard_d = discard_q - ONE_C;

    // Redirect wins: everything still in flight after this cycle is stale.
    if (s_redirect) begin
      pc_d      = s_redirect_pc;
      count_d   = '0;
      discard_d = outstanding_d;
    end
  end

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      pc_q          <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      rd_ptr_q      <= '0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
      // NOTE: the prefetch storage is a handful of flops, so it is reset too and never holds X.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
      run_q         <= 1'b1;
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;

      if (s_redirect) begin
        alloc_ptr_q <= '0;
        fill_ptr_q  <= '0;
        rd_ptr_q    <= '0;
      end else begin
        // A slot's PC is captured at request time; its data lands there when the response returns.
        if (req_fire) begin
          fifo_pc_q[alloc_ptr_q] <= pc_q;
          alloc_ptr_q            <= alloc_ptr_q + PTR_ONE;
        end
        if (push) begin
          fifo_data_q[fill_ptr_q] <= imem_resp_data;
          fill_ptr_q              <= fill_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end

      if (s_redirect) begin
        id_instr_q <= NOP_INSTR;
        id_valid_q <= 1'b0;
      end else if (!s_id_stall) begin
        if (count_q != '0) begin
          id_instr_q <= fifo_data_q[rd_ptr_q];
          id_pc_q    <= fifo_pc_q[rd_ptr_q];
          id_valid_q <= 1'b1;
        end else begin
          id_instr_q <= NOP_INSTR;
          id_valid_q <= 1'b0;
        end
      end
    end
  end

  assign r_id_instr = id_instr_q;
  assign r_id_pc    = id_pc_q;
  assign r_id_valid = id_valid_q;

  no_fifo_overflow : assert property (@(posedge sys_clock) disable iff (!reset_n)
    !(push && (count_q == DEPTH_C)));

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubbles_q;
  logic [31:0] perf_stalls_q;
  logic        bubble_load;

  assign bubble_load = !s_id_stall && !s_redirect && (count_q == '0);

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_bubbles_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (bubble_load && (perf_bubbles_q != '1)) perf_bubbles_q <= perf_bubbles_q + 32'd1;
      if (s_id_stall && (perf_stalls_q != '1))   perf_stalls_q  <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule
